score_reader: RTL

SCORE_READER -- requirements
Module: score_reader

---
 rtl/score_reader.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/score_reader.sv
// score_reader: recovers a two-digit score from a pair of raw 7-segment
// patterns and reconstructs inc/dec/erase/jump events from score changes.
// A pattern pair is accepted only after STABLE_CYCLES identical samples.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   tens_7seg_i  tens segments, [7]=a .. [1]=g, 1 = lit
//   units_7seg_i units segments, same encoding
//   tens_o       BCD tens of the last accepted legal score
//   units_o      BCD units of the last accepted legal score
//   valid_o      a legal score has been accepted since reset
//   inc_o/dec_o/erase_o/jump_o  one-cycle event pulses
//   invalid_o    level, accepted pair is not two legal digits

// Per-digit segment decoder.
module seg_dec (
  input  logic [6:0] seg,
  output logic       ok,
  output logic [3:0] bcd
);
  always_comb begin
    ok  = 1'b1;
    bcd = 4'd0;
    case (seg)
      7'b1111110: bcd = 4'd0;
      7'b0110000: bcd = 4'd1;
      7'b1101101: bcd = 4'd2;
      7'b1111001: bcd = 4'd3;
      7'b0110011: bcd = 4'd4;
      7'b1011011: bcd = 4'd5;
      7'b1011111: bcd = 4'd6;
      7'b1110000: bcd = 4'd7;
      7'b1111111: bcd = 4'd8;
      7'b1111011: bcd = 4'd9;
      default:    ok  = 1'b0;
    endcase
  end
endmodule

module score_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:1] tens_7seg_i,
  input  logic [7:1] units_7seg_i,
  output logic [3:0] tens_o,
  output logic [3:0] units_o,
  output logic       valid_o,
  output logic       inc_o,
  output logic       dec_o,
  output logic       erase_o,
  output logic       jump_o,
  output logic       invalid_o
);
  localparam int NUM_DIG = 2;  // index 1 = tens, 0 = units

  typedef enum logic [1:0] {INIT, TRACK, SETTLE} state_t;

  state_t                         state;
  logic [3:0]                     cnt;
  logic [NUM_DIG-1:0][6:0]        smp, cand, acc;
  logic                           acc_vld;  // acc holds a real pair (legal or not)
  logic [NUM_DIG-1:0]             dig_ok;
  logic [NUM_DIG-1:0][3:0]        dig_bcd;
  logic [6:0]                     p_val, n_val, p_inc, p_dec;
  logic                           cand_ok;

  assign smp = {tens_7seg_i, units_7seg_i};

  // Only the candidate ever needs decoding: it is what gets accepted.
  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dec
    seg_dec u_dec (.seg(cand[g]), .ok(dig_ok[g]), .bcd(dig_bcd[g]));
  end

  assign cand_ok = &dig_ok;
  assign p_val   = 7'(tens_o) * 7'd10 + 7'(units_o);
  assign n_val   = 7'(dig_bcd[1]) * 7'd10 + 7'(dig_bcd[0]);
  assign p_inc   = (p_val == 7'd99) ? 7'd0  : p_val + 7'd1;
  assign p_dec   = (p_val == 7'd0)  ? 7'd99 : p_val - 7'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= INIT;
      cnt       <= 4'd0;
      cand      <= '0;
      acc       <= '0;
      acc_vld   <= 1'b0;
      tens_o    <= 4'd0;
      units_o   <= 4'd0;
      valid_o   <= 1'b0;
      invalid_o <= 1'b0;
      inc_o     <= 1'b0;
      dec_o     <= 1'b0;
      erase_o   <= 1'b0;
      jump_o    <= 1'b0;
    end else begin
      inc_o   <= 1'b0;
      dec_o   <= 1'b0;
      erase_o <= 1'b0;
      jump_o  <= 1'b0;
      case (state)
        INIT: begin
          cand  <= smp;
          cnt   <= 4'd1;
          state <= SETTLE;
        end
        TRACK: begin
          if (smp != acc) begin
            cand  <= smp;
            cnt   <= 4'd1;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt >= 4'(STABLE_CYCLES)) begin
            // Candidate held for the full window: accept it.
            acc     <= cand;
            acc_vld <= 1'b1;
            cnt     <= 4'd0;
            state   <= TRACK;
            if (cand_ok) begin
              tens_o    <= dig_bcd[1];
              units_o   <= dig_bcd[0];
              valid_o   <= 1'b1;
              invalid_o <= 1'b0;
              // Compare against the last legal score; none yet means no event.
              if (valid_o) begin
                if      (n_val == p_inc) inc_o   <= 1'b1;
                else if (n_val == p_dec) dec_o   <= 1'b1;
                else if (n_val == 7'd0)  erase_o <= 1'b1;
                else                     jump_o  <= 1'b1;
              end
            end else begin
              invalid_o <= 1'b1;
            end
          end else if (smp == cand) begin
            cnt <= cnt + 4'd1;
          end else if (acc_vld && smp == acc) begin
            cnt   <= 4'd0;
            state <= TRACK;
          end else begin
            cand <= smp;
            cnt  <= 4'd1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule
